muldiv: RTL
===========

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is required to be supported.
REQ-002 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: start  in  1  request to begin operation op on a, b.
REQ-005 SHALL have ports: op  in  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-006 SHALL have ports: a, b  in  32 each  operands, sampled only on the accepting edge.
REQ-007 SHALL have ports: hi_we, lo_we  in  1 each  direct write of wdata into HI/LO (mthi/mtlo).
REQ-008 SHALL have ports: wdata  in  32  data for hi_we/lo_we.
REQ-009 SHALL have ports: hi, lo  out  32 each  HiLo register contents (mfhi/mflo).
REQ-010 SHALL have ports: busy  out  1  operation in progress.
REQ-011 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports: div_by_zero  out  1  last accepted op was div/divu with b == 0.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-014 Transitions SHALL be: IDLE/DONE + start -> CALC; CALC after 32 iterations -> FIX; FIX -> DONE; DONE without start -> IDLE.
REQ-015 start in CALC or FIX SHALL be ignored; operands SHALL be latched only when start is accepted.
REQ-016 Multiply SHALL be radix-2 shift-add, one bit per cycle, on operand magnitudes.
REQ-017 Divide SHALL be restoring, one quotient bit per cycle, on operand magnitudes.
REQ-018 FIX SHALL apply sign correction for signed ops:
- product negated when a[31] XOR b[31]
- quotient negated when a[31] XOR b[31]
- remainder takes the sign of a.
REQ-019 Results SHALL be written on the edge leaving FIX: mult/multu {hi,lo} = 64-bit product; div/divu lo = quotient, hi = remainder.
REQ-020 Latency: start sampled at edge 0 -> done high for exactly one cycle after edge 33; hi/lo SHALL hold the new result while done is high.
REQ-021 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-022 div/divu with b == 0 SHALL skip CALC, going IDLE -> FIX -> DONE (done after edge 2), with hi = a, lo = 32'hFFFFFFFF, div_by_zero = 1.
REQ-023 div_by_zero SHALL clear on any later accepted start with a nonzero divisor or a multiply op.
REQ-024 Signed div 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0 with no flag.
REQ-025 hi_we/lo_we SHALL take effect only when busy = 0; they are ignored while busy.
REQ-026 If start and hi_we/lo_we occur on the same edge, start SHALL win and the write SHALL be dropped.
REQ-027 Result write leaving FIX SHALL not coincide with a direct write, since busy = 1 in FIX.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, hi = lo = 0, busy = done = div_by_zero = 0, and clear internal registers, including mid-operation.
REQ-029 After rst_n release, the first start SHALL behave as in REQ-020 with no residue of the aborted operation.

Structure
REQ-030 Package muldiv_pkg SHALL hold the op encoding enum, the FSM state enum, and constants WIDTH = 32 and ITER = 32.
REQ-031 One sub-module muldiv_sign SHALL provide combinational absolute value and conditional two's-complement negation, instanced for operand magnitude and result fix-up.

Verification
REQ-032 SHALL test mult a = 0xFFFFFFFF, b = 2 -> done at cycle 33, hi = 0xFFFFFFFF, lo = 0xFFFFFFFE.
REQ-033 SHALL test multu a = 0xFFFFFFFF, b = 2 -> hi = 0x00000001, lo = 0xFFFFFFFE.
REQ-034 SHALL test div a = -7, b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; divu a = 100, b = 7 -> lo = 0x0E, hi = 0x02.
REQ-035 SHALL test divu a = 5, b = 0 -> done after edge 2, hi = 5, lo = 0xFFFFFFFF, div_by_zero = 1.
REQ-036 SHALL test start while busy plus hi_we with wdata = 0x1234 -> both ignored, original result delivered; hi_we in IDLE -> hi = 0x1234 next cycle.
REQ-037 SHALL test rst_n low at cycle 10 of a mult -> busy = done = 0, hi = lo = 0 immediately; new multu 3 x 4 after release -> lo = 12 at cycle 33.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding, controller states and the fixed datapath width/iteration count.
package muldiv_pkg;

   localparam int WIDTH = 32;
   localparam int ITER  = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_t;

   // True for the two-operand signed operations
   function automatic logic op_is_signed(op_t o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

   // True for the divide operations
   function automatic logic op_is_div(op_t o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_sign.sv
// Conditional two's-complement negation. Driving negate with the value's own
// sign bit yields the absolute value; driving it with a result-sign flag
// applies the sign fix-up after an unsigned magnitude operation.
module muldiv_sign #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         negate,
   output logic [W-1:0] result
);

   // Pass through or negate
   always_comb begin
      result = negate ? (~value + 1'b1) : value;
   end

endmodule

// File: rtl/muldiv.sv
// Iterative HI/LO multiply/divide unit. Multiplies by radix-2 shift-add and
// divides by restoring division, one bit per cycle on operand magnitudes,
// then fixes up signs in a single FIX cycle before writing HI/LO.
module muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   import muldiv_pkg::*;

   state_t             state;
   op_t                op_q;
   op_t                op_in;
   logic [5:0]         cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   operand;
   logic               neg_res;
   logic               rem_neg;
   logic               fix_hold;

   logic               in_signed;
   logic               in_div;
   logic               in_dbz;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign op_in = op_t'(op);

   // Decode the incoming request so operands can be latched as magnitudes
   always_comb begin
      in_signed = op_is_signed(op_in);
      in_div    = op_is_div(op_in);
      in_dbz    = in_div && (b == '0);
   end

   muldiv_sign #(.W(WIDTH)) u_abs_a (
      .value  (a),
      .negate (in_signed & a[WIDTH-1]),
      .result (a_mag)
   );

   muldiv_sign #(.W(WIDTH)) u_abs_b (
      .value  (b),
      .negate (in_signed & b[WIDTH-1]),
      .result (b_mag)
   );

   muldiv_sign #(.W(2*WIDTH)) u_fix_prod (
      .value  (acc),
      .negate (neg_res),
      .result (prod_fix)
   );

   muldiv_sign #(.W(WIDTH)) u_fix_quot (
      .value  (acc[WIDTH-1:0]),
      .negate (neg_res),
      .result (quot_fix)
   );

   muldiv_sign #(.W(WIDTH)) u_fix_rem (
      .value  (acc[2*WIDTH-1:WIDTH]),
      .negate (rem_neg),
      .result (rem_fix)
   );

   // One iteration step for each algorithm. For multiply, acc holds the
   // partial product above the not-yet-consumed multiplier bits; for divide,
   // acc holds the partial remainder above the dividend/quotient shifter.
   always_comb begin
      mul_sum   = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand})
                         : {1'b0, acc[2*WIDTH-1:WIDTH]};
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_ge    = div_shift >= {1'b0, operand};
      div_diff  = div_shift[WIDTH-1:0] - operand;
      div_next  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                         : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   end

   // Controller, datapath and HI/LO registers. A zero divisor skips CALC and
   // spends two cycles in FIX so the completion pulse follows the second edge;
   // its result (a, all-ones) is preloaded into acc and written unmodified.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_q        <= OP_MULT;
         cnt         <= '0;
         acc         <= '0;
         operand     <= '0;
         neg_res     <= 1'b0;
         rem_neg     <= 1'b0;
         fix_hold    <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  op_q        <= op_in;
                  cnt         <= '0;
                  neg_res     <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  rem_neg     <= in_signed & a[WIDTH-1];
                  div_by_zero <= in_dbz;
                  busy        <= 1'b1;
                  if (in_dbz) begin
                     acc      <= {a, {WIDTH{1'b1}}};
                     operand  <= '0;
                     fix_hold <= 1'b1;
                     state    <= FIX;
                  end else if (in_div) begin
                     acc      <= {{WIDTH{1'b0}}, a_mag};
                     operand  <= b_mag;
                     fix_hold <= 1'b0;
                     state    <= CALC;
                  end else begin
                     acc      <= {{WIDTH{1'b0}}, b_mag};
                     operand  <= a_mag;
                     fix_hold <= 1'b0;
                     state    <= CALC;
                  end
               end else begin
                  state <= IDLE;
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            CALC: begin
               acc <= op_is_div(op_q) ? div_next : mul_next;
               cnt <= cnt + 6'd1;
               if (cnt == 6'(ITER - 1)) state <= FIX;
            end
            FIX: begin
               if (fix_hold) begin
                  fix_hold <= 1'b0;
               end else begin
                  if (div_by_zero) begin
                     hi <= acc[2*WIDTH-1:WIDTH];
                     lo <= acc[WIDTH-1:0];
                  end else if (op_is_div(op_q)) begin
                     hi <= rem_fix;
                     lo <= quot_fix;
                  end else begin
                     hi <= prod_fix[2*WIDTH-1:WIDTH];
                     lo <= prod_fix[WIDTH-1:0];
                  end
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
